// File: rtl/aes256_round_ctrl_if.sv
// Handshake and datapath bus for the AES round controller.
//   pt_valid/pt_ready/pt : plaintext stream into the controller
//   rk_idx/rk            : round key index out, key returned same cycle
//   dp_state/dp_final/dp_result : external combinational round datapath
//   ct_valid/ct_ready/ct : ciphertext stream out of the controller
//   busy                 : controller not idle
// slave  = controller side, master = environment (source, key store,
// datapath, sink).
interface aes256_round_ctrl_if #(
  parameter int RKW = 4
);
  logic           pt_valid;
  logic           pt_ready;
  logic [127:0]   pt;
  logic [RKW-1:0] rk_idx;
  logic [127:0]   rk;
  logic [127:0]   dp_state;
  logic           dp_final;
  logic [127:0]   dp_result;
  logic           ct_valid;
  logic           ct_ready;
  logic [127:0]   ct;
  logic           busy;

  modport slave (
    input  pt_valid, pt, rk, dp_result, ct_ready,
    output pt_ready, rk_idx, dp_state, dp_final, ct_valid, ct, busy
  );

  modport master (
    output pt_valid, pt, rk, dp_result, ct_ready,
    input  pt_ready, rk_idx, dp_state, dp_final, ct_valid, ct, busy
  );
endinterface

// File: rtl/aes256_round_ctrl.sv
// Iterative AES round sequencer. Owns the 128-bit state register and the
// round counter, drives the external round datapath and the key store
// index, and moves one block at a time between the plaintext and
// ciphertext valid/ready streams.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   abort : (only with AES_ROUND_CTRL_ABORT_EN) drop the block in flight
//   bus   : aes256_round_ctrl_if.slave (pt/rk/dp/ct streams, busy)
// Parameters: NR rounds (2..14), RKW key index width (2^RKW > NR).
// Optional feature macro: AES_ROUND_CTRL_ABORT_EN.
module aes256_round_ctrl #(
  parameter int NR  = 14,
  parameter int RKW = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic abort,
`endif
  aes256_round_ctrl_if.slave bus
);

  localparam int              RNDW = $clog2(NR + 1);
  localparam logic [RNDW-1:0] LAST = RNDW'(NR);
  localparam logic [RNDW-1:0] ONE  = RNDW'(1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t          st;
  logic [RNDW-1:0] rnd;
  logic [RNDW-1:0] rk_idx_q;
  logic [127:0]    state_q;
  logic            pt_ok;
  logic            dp_final_q;
  logic            ct_valid_q;
  logic            busy_q;
  logic            flush;

`ifdef AES_ROUND_CTRL_ABORT_EN
  // Abort only matters with a block in flight; in IDLE it is a no-op so a
  // coincident plaintext handshake still goes through.
  assign flush = abort && (st != IDLE);
`else
  assign flush = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      st         <= IDLE;
      rnd        <= '0;
      rk_idx_q   <= '0;
      state_q    <= '0;
      pt_ok      <= 1'b1;
      dp_final_q <= 1'b0;
      ct_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (bus.pt_valid && pt_ok) begin
            // Initial AddRoundKey uses key 0, which rk_idx selects in IDLE.
            state_q    <= bus.pt ^ bus.rk;
            rnd        <= ONE;
            rk_idx_q   <= ONE;
            dp_final_q <= (LAST == ONE);
            pt_ok      <= 1'b0;
            busy_q     <= 1'b1;
            st         <= ROUND;
          end
        end
        ROUND: begin
          state_q <= bus.dp_result;
          if (rnd == LAST) begin
            rk_idx_q   <= '0;
            dp_final_q <= 1'b0;
            ct_valid_q <= 1'b1;
            st         <= DONE;
          end else begin
            // Outputs are registered, so they are loaded with the value
            // belonging to the next round.
            rnd        <= rnd + ONE;
            rk_idx_q   <= rnd + ONE;
            dp_final_q <= ((rnd + ONE) == LAST);
          end
        end
        DONE: begin
          // The IDLE cycle after the ct handshake is the single bubble
          // between blocks; pt_ready never overlaps ct_valid.
          if (bus.ct_ready) begin
            rnd        <= '0;
            ct_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            pt_ok      <= 1'b1;
            st         <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.pt_ready = pt_ok && !rst;
  assign bus.rk_idx   = RKW'(rk_idx_q);
  assign bus.dp_state = state_q;
  assign bus.dp_final = dp_final_q;
  assign bus.ct_valid = ct_valid_q;
  assign bus.ct       = state_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_aes256_round_ctrl.sv
// Bench for aes256_round_ctrl: an AES-256 instance (NR=14) and an AES-128
// instance (NR=10), each closed around a reference key schedule and
// round function. Expected ciphertexts queue at the plaintext handshake
// and are popped at the ciphertext handshake.
module tb_aes256_round_ctrl;
  localparam int NR_A = 14;
  localparam int NR_B = 10;
  localparam int RKW  = 4;

  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  int           cyc = 0;
  int           vec = 0;
  int           err = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   sbox_t [256];
  logic [127:0] rks_a [16];
  logic [127:0] rks_b [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes256_round_ctrl_if #(.RKW(RKW)) ifa ();
  aes256_round_ctrl_if #(.RKW(RKW)) ifb ();

`ifdef AES_ROUND_CTRL_ABORT_EN
  logic abort_a = 1'b0;
  logic abort_b = 1'b0;
`endif

  aes256_round_ctrl #(.NR(NR_A), .RKW(RKW)) u_a (
    .clk(clk), .rst(rst),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort_a),
`endif
    .bus(ifa)
  );

  aes256_round_ctrl #(.NR(NR_B), .RKW(RKW)) u_b (
    .clk(clk), .rst(rst),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort_b),
`endif
    .bus(ifb)
  );

  // ---------------- reference AES model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv;
      s = inv;
      for (int n = 0; n < 4; n++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox_t[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr,
                        output logic [127:0] rk [16]);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 64; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (fin)
        o[127-32*c -: 32] = {a0, a1, a2, a3};
      else
        o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                             xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o ^ k;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] rk [16],
                                           input int nr);
    logic [127:0] s;
    s = p ^ rk[0];
    for (int r = 1; r <= nr; r++) s = aes_round(s, rk[r], r == nr);
    return s;
  endfunction

  // Key store and round datapath closed around each controller.
  assign ifa.rk        = rks_a[ifa.rk_idx];
  assign ifa.dp_result = aes_round(ifa.dp_state, ifa.rk, ifa.dp_final);
  assign ifb.rk        = rks_b[ifb.rk_idx];
  assign ifb.dp_result = aes_round(ifb.dp_state, ifb.rk, ifb.dp_final);

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers (instance A) ----------------
  task automatic send_a(input logic [127:0] p, input logic [127:0] e, output int h);
    int k;
    ifa.pt = p;
    ifa.pt_valid = 1'b1;
    k = 0;
    while (ifa.pt_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (ifa.pt_ready !== 1'b1) begin
      vec++; err++;
      $display("FAIL send_timeout: pt_ready=%b, required 1", ifa.pt_ready);
      h = -1;
      ifa.pt_valid = 1'b0;
      return;
    end
    h = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    ifa.pt_valid = 1'b0;
  endtask

  task automatic drain_a(input string tag);
    logic [127:0] e;
    int k;
    k = 0;
    while (ifa.ct_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    vec++;
    if (ifa.ct_valid !== 1'b1 || exp_q.size() == 0) begin
      err++;
      $display("FAIL %s_ct_valid: ct_valid=%b queued=%0d, required 1 and 1", tag, ifa.ct_valid, exp_q.size());
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    ifa.ct_ready = 1'b1;
    if (ifa.ct !== e) begin
      err++;
      $display("FAIL %s_ct: got %h, required %h", tag, ifa.ct, e);
    end
    @(negedge clk);
    ifa.ct_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    ifa.pt_valid = 1'b1;
    ifb.pt_valid = 1'b1;
    repeat (2) @(negedge clk);
    vec++;
    if (ifa.pt_ready !== 1'b0 || ifb.pt_ready !== 1'b0) begin
      err++;
      $display("FAIL reset_pt_ready: a=%b b=%b, required 0 0", ifa.pt_ready, ifb.pt_ready);
    end
    rst = 1'b0;
    ifa.pt_valid = 1'b0;
    ifb.pt_valid = 1'b0;
    @(negedge clk);
    vec++;
    if ({ifa.busy, ifa.ct_valid, ifa.pt_ready, ifa.dp_final, ifa.rk_idx} !== 8'b0010_0000 ||
        ifa.dp_state !== 128'h0) begin
      err++;
      $display("FAIL reset_a: busy/ctv/ptr/fin/idx=%b state=%h, required 00100000 and 0",
               {ifa.busy, ifa.ct_valid, ifa.pt_ready, ifa.dp_final, ifa.rk_idx}, ifa.dp_state);
    end
    vec++;
    if ({ifb.busy, ifb.ct_valid, ifb.pt_ready, ifb.dp_final, ifb.rk_idx} !== 8'b0010_0000 ||
        ifb.dp_state !== 128'h0) begin
      err++;
      $display("FAIL reset_b: busy/ctv/ptr/fin/idx=%b state=%h, required 00100000 and 0",
               {ifb.busy, ifb.ct_valid, ifb.pt_ready, ifb.dp_final, ifb.rk_idx}, ifb.dp_state);
    end
  endtask

  task automatic test_fips256();
    int  h, k;
    bit  seq_ok, fin_ok;
    ifa.pt = PT;
    ifa.pt_valid = 1'b1;
    k = 0;
    while (ifa.pt_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    vec++;
    if (ifa.pt_ready !== 1'b1 || ifa.rk_idx !== 4'd0) begin
      err++;
      $display("FAIL fips256_accept: pt_ready=%b rk_idx=%0d, required 1 and 0", ifa.pt_ready, ifa.rk_idx);
      ifa.pt_valid = 1'b0;
      return;
    end
    h = cyc;
    exp_q.push_back(CT256);
    @(negedge clk);
    ifa.pt_valid = 1'b0;
    seq_ok = 1'b1;
    fin_ok = 1'b1;
    k = 1;
    while (ifa.ct_valid !== 1'b1 && k <= 40) begin
      if (ifa.rk_idx !== 4'(k) || ifa.busy !== 1'b1) seq_ok = 1'b0;
      if (ifa.dp_final !== (k == NR_A)) fin_ok = 1'b0;
      k++;
      @(negedge clk);
    end
    vec++;
    if (!seq_ok) begin
      err++;
      $display("FAIL fips256_rk_seq: rk_idx/busy deviated from 1..14, required 1..14 with busy");
    end
    vec++;
    if (!fin_ok) begin
      err++;
      $display("FAIL fips256_dp_final: dp_final not exclusive to rk_idx 14, required only at 14");
    end
    vec++;
    if (ifa.ct_valid !== 1'b1 || cyc - h != NR_A + 1) begin
      err++;
      $display("FAIL fips256_latency: %0d cycles ct_valid=%b, required %0d and 1", cyc - h, ifa.ct_valid, NR_A + 1);
    end
    vec++;
    if ({ifa.rk_idx, ifa.dp_final, ifa.busy, ifa.pt_ready} !== 7'b0000_010) begin
      err++;
      $display("FAIL fips256_done_outs: idx/fin/busy/ptr=%b, required 0000010",
               {ifa.rk_idx, ifa.dp_final, ifa.busy, ifa.pt_ready});
    end
    drain_a("fips256");
    vec++;
    if ({ifa.ct_valid, ifa.busy, ifa.pt_ready} !== 3'b001) begin
      err++;
      $display("FAIL fips256_idle: ctv/busy/ptr=%b, required 001", {ifa.ct_valid, ifa.busy, ifa.pt_ready});
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] p, hold, e;
    int h, k;
    p = rnd128();
    send_a(p, aes_enc(p, rks_a, NR_A), h);
    k = 0;
    while (ifa.ct_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    hold = ifa.ct;
    for (int i = 0; i < 20; i++) begin
      ifa.pt_valid = i[0];
      ifa.pt = ~p ^ 128'(i);
      @(negedge clk);
      vec++;
      if (ifa.ct !== hold || {ifa.ct_valid, ifa.busy, ifa.pt_ready} !== 3'b110) begin
        err++;
        $display("FAIL bp_hold[%0d]: ct=%h ctv/busy/ptr=%b, required %h and 110",
                 i, ifa.ct, {ifa.ct_valid, ifa.busy, ifa.pt_ready}, hold);
      end
    end
    ifa.pt_valid = 1'b0;
    ifa.ct_ready = 1'b1;
    e = exp_q.size() > 0 ? exp_q.pop_front() : 128'hx;
    vec++;
    if (ifa.ct !== e) begin
      err++;
      $display("FAIL bp_ct: got %h, required %h", ifa.ct, e);
    end
    @(negedge clk);
    ifa.ct_ready = 1'b0;
    vec++;
    if ({ifa.ct_valid, ifa.busy, ifa.pt_ready} !== 3'b001) begin
      err++;
      $display("FAIL bp_idle: ctv/busy/ptr=%b, required 001", {ifa.ct_valid, ifa.busy, ifa.pt_ready});
    end
    @(negedge clk);
    vec++;
    if (ifa.busy !== 1'b0) begin
      err++;
      $display("FAIL bp_ignored_pt: busy=%b, required 0", ifa.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] p1, p2, e1, e2, e;
    int h1, h2, got;
    p1 = rnd128();
    p2 = rnd128();
    e1 = aes_enc(p1, rks_a, NR_A);
    e2 = aes_enc(p2, rks_a, NR_A);
    h1 = -1; h2 = -1; got = 0;
    ifa.ct_ready = 1'b1;
    ifa.pt = p1;
    ifa.pt_valid = 1'b1;
    for (int i = 0; i < 80 && got < 2; i++) begin
      if (ifa.ct_valid === 1'b1) begin
        e = exp_q.size() > 0 ? exp_q.pop_front() : 128'hx;
        got++;
        vec++;
        if (ifa.ct !== e) begin
          err++;
          $display("FAIL b2b_ct%0d: got %h, required %h", got, ifa.ct, e);
        end
      end
      if (ifa.pt_valid && ifa.pt_ready === 1'b1) begin
        if (h1 < 0) begin h1 = cyc; exp_q.push_back(e1); end
        else        begin h2 = cyc; exp_q.push_back(e2); end
      end
      @(negedge clk);
      if (h1 >= 0 && h2 < 0) ifa.pt = p2;
      if (h2 >= 0) ifa.pt_valid = 1'b0;
    end
    ifa.pt_valid = 1'b0;
    ifa.ct_ready = 1'b0;
    // Handshake cycles T and T+NR+2: the span counted inclusively is 17.
    vec++;
    if (h1 < 0 || h2 < 0 || h2 - h1 != NR_A + 2) begin
      err++;
      $display("FAIL b2b_spacing: %0d cycles, required %0d", h2 - h1, NR_A + 2);
    end
    vec++;
    if (got != 2) begin
      err++;
      $display("FAIL b2b_count: %0d ciphertexts, required 2", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] p;
    int h, k;
    bit none;
    p = rnd128();
    send_a(p, aes_enc(p, rks_a, NR_A), h);
    k = 0;
    while (ifa.rk_idx !== 4'd7 && k < 30) begin
      @(negedge clk);
      k++;
    end
    vec++;
    if (ifa.rk_idx !== 4'd7) begin
      err++;
      $display("FAIL rstmid_round7: rk_idx=%0d, required 7", ifa.rk_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    vec++;
    if ({ifa.busy, ifa.pt_ready, ifa.ct_valid} !== 3'b010 || ifa.dp_state !== 128'h0) begin
      err++;
      $display("FAIL rstmid_idle: busy/ptr/ctv=%b state=%h, required 010 and 0",
               {ifa.busy, ifa.pt_ready, ifa.ct_valid}, ifa.dp_state);
    end
    @(negedge clk);
    none = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ifa.ct_valid !== 1'b0) none = 1'b0;
      @(negedge clk);
    end
    vec++;
    if (!none) begin
      err++;
      $display("FAIL rstmid_no_ct: ct_valid seen, required none");
    end
    p = rnd128();
    send_a(p, aes_enc(p, rks_a, NR_A), h);
    drain_a("rstmid_next");
  endtask

  task automatic test_nr10();
    int h, k;
    bit seq_ok, fin_ok;
    ifb.pt = PT;
    ifb.pt_valid = 1'b1;
    k = 0;
    while (ifb.pt_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    h = cyc;
    @(negedge clk);
    ifb.pt_valid = 1'b0;
    seq_ok = 1'b1;
    fin_ok = 1'b1;
    k = 1;
    while (ifb.ct_valid !== 1'b1 && k <= 30) begin
      if (ifb.rk_idx !== 4'(k)) seq_ok = 1'b0;
      if (ifb.dp_final !== (k == NR_B)) fin_ok = 1'b0;
      k++;
      @(negedge clk);
    end
    vec++;
    if (!seq_ok || !fin_ok) begin
      err++;
      $display("FAIL nr10_seq: rk_seq_ok=%b dp_final_ok=%b, required 1 1", seq_ok, fin_ok);
    end
    vec++;
    if (ifb.ct_valid !== 1'b1 || cyc - h != NR_B + 1) begin
      err++;
      $display("FAIL nr10_latency: %0d cycles ct_valid=%b, required %0d and 1", cyc - h, ifb.ct_valid, NR_B + 1);
    end
    vec++;
    if (ifb.ct !== CT128) begin
      err++;
      $display("FAIL nr10_ct: got %h, required %h", ifb.ct, CT128);
    end
    ifb.ct_ready = 1'b1;
    @(negedge clk);
    ifb.ct_ready = 1'b0;
    vec++;
    if ({ifb.ct_valid, ifb.busy, ifb.pt_ready} !== 3'b001) begin
      err++;
      $display("FAIL nr10_idle: ctv/busy/ptr=%b, required 001", {ifb.ct_valid, ifb.busy, ifb.pt_ready});
    end
  endtask

`ifdef AES_ROUND_CTRL_ABORT_EN
  task automatic test_abort();
    logic [127:0] p;
    int h, k;
    bit none;
    p = rnd128();
    send_a(p, aes_enc(p, rks_a, NR_A), h);
    k = 0;
    while (ifa.rk_idx !== 4'd3 && k < 30) begin
      @(negedge clk);
      k++;
    end
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    vec++;
    if ({ifa.busy, ifa.pt_ready, ifa.ct_valid} !== 3'b010 || ifa.dp_state !== 128'h0) begin
      err++;
      $display("FAIL abort_idle: busy/ptr/ctv=%b state=%h, required 010 and 0",
               {ifa.busy, ifa.pt_ready, ifa.ct_valid}, ifa.dp_state);
    end
    none = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ifa.ct_valid !== 1'b0) none = 1'b0;
      @(negedge clk);
    end
    vec++;
    if (!none) begin
      err++;
      $display("FAIL abort_no_ct: ct_valid seen, required none");
    end
    // Abort raised in IDLE alongside a plaintext handshake.
    p = rnd128();
    abort_a = 1'b1;
    ifa.pt = p;
    ifa.pt_valid = 1'b1;
    exp_q.push_back(aes_enc(p, rks_a, NR_A));
    @(negedge clk);
    abort_a = 1'b0;
    ifa.pt_valid = 1'b0;
    vec++;
    if (ifa.busy !== 1'b1 || ifa.rk_idx !== 4'd1) begin
      err++;
      $display("FAIL abort_idle_accept: busy=%b rk_idx=%0d, required 1 and 1", ifa.busy, ifa.rk_idx);
    end
    drain_a("abort_idle");
  endtask
`endif

  initial begin
    ifa.pt_valid = 1'b0; ifa.pt = '0; ifa.ct_ready = 1'b0;
    ifb.pt_valid = 1'b0; ifb.pt = '0; ifb.ct_ready = 1'b0;
    build_sbox();
    expand(K256, 8, NR_A, rks_a);
    expand(K128, 4, NR_B, rks_b);
    test_reset();
    test_fips256();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_nr10();
`ifdef AES_ROUND_CTRL_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end
endmodule
